// File: rtl/quaternion_pkg.sv
// Shared constants and FSM encoding for the quaternion result serializer.
// Imported by the serializer top and its round/saturate helper.
package quaternion_pkg;

  localparam int QUAT_IN_W  = 32;
  localparam int QUAT_OUT_W = 16;
  localparam int QUAT_NCOMP = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/quaternion_round_sat.sv
// Rescale one signed component by FRAC_BITS (round half up), then clip to OUT_W.
// Ports: i_q (IN_W signed in), o_value (OUT_W signed out), o_sat (clipped flag).
module quaternion_round_sat #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic signed [IN_W-1:0]  i_q,
  output logic signed [OUT_W-1:0] o_value,
  output logic                    o_sat
);

  // One extra bit so the rounding add cannot wrap.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] MAXV =
    EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_t;

  assign w_ext = EW'(i_q);

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF =
        EW'(64'sd1 <<< (FRAC_BITS - 1));
      assign w_t = (w_ext + HALF) >>> FRAC_BITS;
    end else begin : g_pass
      assign w_t = w_ext;
    end
  endgenerate

  always_comb begin
    o_sat   = 1'b0;
    o_value = w_t[OUT_W-1:0];
    if (w_t > MAXV) begin
      o_value = MAXV[OUT_W-1:0];
      o_sat   = 1'b1;
    end else if (w_t < MINV) begin
      o_value = MINV[OUT_W-1:0];
      o_sat   = 1'b1;
    end
  end

endmodule

// File: rtl/quaternion_result_serializer.sv
// Capture a converted quaternion and stream it as four valid/ready beats.
// Ports: clk, rst (async low), in_valid/in_ready, q0..q3, out_* beat stream.
module quaternion_result_serializer
  import quaternion_pkg::*;
#(
  parameter int IN_W      = QUAT_IN_W,
  parameter int OUT_W     = QUAT_OUT_W,
  parameter int FRAC_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  q0,
  input  logic signed [IN_W-1:0]  q1,
  input  logic signed [IN_W-1:0]  q2,
  input  logic signed [IN_W-1:0]  q3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_last,
  output logic                    out_sat
);

  state_e                  r_state;
  logic [1:0]              r_cnt;
  logic [OUT_W:0]          r_res [QUAT_NCOMP];
  logic signed [OUT_W-1:0] r_data;
  logic                    r_last;
  logic                    r_sat;

  logic signed [IN_W-1:0]  w_q   [QUAT_NCOMP];
  logic signed [OUT_W-1:0] w_val [QUAT_NCOMP];
  logic [QUAT_NCOMP-1:0]   w_sat;
  logic                    w_end;
  logic                    w_fire;
  logic                    w_accept;
  logic [1:0]              w_nxt;

  assign w_q[0] = q0;
  assign w_q[1] = q1;
  assign w_q[2] = q2;
  assign w_q[3] = q3;

  generate
    for (genvar g = 0; g < QUAT_NCOMP; g++) begin : g_conv
      quaternion_round_sat #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
      ) u_rs (
        .i_q     (w_q[g]),
        .o_value (w_val[g]),
        .o_sat   (w_sat[g])
      );
    end
  endgenerate

  assign out_valid = (r_state == SEND);
  assign out_data  = r_data;
  assign out_idx   = r_cnt;
  assign out_last  = r_last;
  assign out_sat   = r_sat;

  assign w_end    = (r_cnt == 2'd3);
  assign w_fire   = out_valid & out_ready;
  // Last beat leaving frees the slot in the same cycle.
  assign in_ready = (r_state == IDLE) | (out_ready & w_end);
  assign w_accept = in_valid & in_ready;
  assign w_nxt    = r_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sat   <= 1'b0;
      for (int i = 0; i < QUAT_NCOMP; i++) begin
        r_res[i] <= '0;
      end
    end else if (w_accept) begin
      r_state <= SEND;
      r_cnt   <= 2'd0;
      r_data  <= w_val[0];
      r_sat   <= w_sat[0];
      r_last  <= 1'b0;
      for (int i = 0; i < QUAT_NCOMP; i++) begin
        r_res[i] <= {w_sat[i], w_val[i]};
      end
    end else if (w_fire) begin
      if (w_end) begin
        r_state <= IDLE;
      end else begin
        r_cnt  <= w_nxt;
        r_data <= r_res[w_nxt][OUT_W-1:0];
        r_sat  <= r_res[w_nxt][OUT_W];
        r_last <= (w_nxt == 2'd3);
      end
    end
  end

endmodule

// File: tb/tb_quaternion_result_serializer.sv
// Directed bench for quaternion_result_serializer (FRAC_BITS 0 and 8).
// Inputs change on the falling edge; outputs are checked there too.
module tb_quaternion_result_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [31:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;

  logic               rdy0, vld0, last0, sat0;
  logic signed [15:0] dat0;
  logic [1:0]         idx0;
  logic               rdy8, vld8, last8, sat8;
  logic signed [15:0] dat8;
  logic [1:0]         idx8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quaternion_result_serializer #(.FRAC_BITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
    .out_idx(idx0), .out_last(last0), .out_sat(sat0)
  );

  quaternion_result_serializer #(.FRAC_BITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .out_valid(vld8), .out_ready(out_ready), .out_data(dat8),
    .out_idx(idx8), .out_last(last8), .out_sat(sat8)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vld0, dat0, idx0, last0, sat0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_out0: got v=%b d=%0d i=%0d l=%b s=%b want 0",
               vld0, dat0, idx0, last0, sat0);
    end
    checks++;
    if ({vld8, dat8, idx8, last8, sat8} !== 21'd0) begin
      errors++;
      $display("FAIL reset_out8: got v=%b d=%0d want 0", vld8, dat8);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 1/1", rdy0, rdy8);
    end
  endtask

  task automatic test_frac0_basic();
    logic signed [15:0] e [4] = '{-60, 12, 30, 24};
    @(negedge clk);
    q0 = -60; q1 = 12; q2 = 30; q3 = 24;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vld0 !== 1'b1 || dat0 !== e[i] || idx0 !== 2'(i) ||
          last0 !== (i == 3) || sat0 !== 1'b0) begin
        errors++;
        $display("FAIL t1_beat%0d: got v=%b d=%0d i=%0d l=%b s=%b want 1 %0d %0d %b 0",
                 i, vld0, dat0, idx0, last0, sat0, e[i], i, i == 3);
      end
      @(negedge clk);
    end
    checks++;
    if (vld0 !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle: got out_valid=%b want 0", vld0);
    end
  endtask

  task automatic test_frac8_round();
    logic signed [15:0] e [4] = '{2, -1, 1, -1};
    @(negedge clk);
    q0 = 384; q1 = -384; q2 = 128; q3 = -129;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vld8 !== 1'b1 || dat8 !== e[i] || idx8 !== 2'(i) ||
          last8 !== (i == 3) || sat8 !== 1'b0) begin
        errors++;
        $display("FAIL t2_beat%0d: got v=%b d=%0d i=%0d l=%b s=%b want 1 %0d %0d %b 0",
                 i, vld8, dat8, idx8, last8, sat8, e[i], i, i == 3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] e [4] = '{32767, -32768, 32767, -32768};
    logic s [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    q0 = 100000; q1 = -100000; q2 = 32767; q3 = -32768;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vld0 !== 1'b1 || dat0 !== e[i] || sat0 !== s[i]) begin
        errors++;
        $display("FAIL t3_beat%0d: got v=%b d=%0d s=%b want 1 %0d %b",
                 i, vld0, dat0, sat0, e[i], s[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int ne = 0;
    @(negedge clk);
    q0 = 1; q1 = 2; q2 = 3; q3 = 4;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k];
      checks++;
      if (vld0 !== 1'b1 || dat0 !== 16'(ne + 1) || idx0 !== 2'(ne) ||
          last0 !== (ne == 3)) begin
        errors++;
        $display("FAIL t4_cyc%0d: got v=%b d=%0d i=%0d l=%b want 1 %0d %0d %b",
                 k, vld0, dat0, idx0, last0, ne + 1, ne, ne == 3);
      end
      if (pat[k]) ne++;
      @(negedge clk);
    end
    checks++;
    if (vld0 !== 1'b0 || ne != 4) begin
      errors++;
      $display("FAIL t4_end: got out_valid=%b transfers=%0d want 0 4", vld0, ne);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge clk);
    q0 = 10; q1 = 11; q2 = 12; q3 = 13;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    q0 = 20; q1 = 21; q2 = 22; q3 = 23;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      #1;
      e = (i < 4) ? 10 + i : 16 + i;
      checks++;
      if (vld0 !== 1'b1 || dat0 !== 16'(e) || idx0 !== 2'(i % 4) ||
          rdy0 !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL t5_beat%0d: got v=%b d=%0d i=%0d rdy=%b want 1 %0d %0d %b",
                 i, vld0, dat0, idx0, rdy0, e, i % 4, (i % 4) == 3);
      end
      @(negedge clk);
    end
    checks++;
    if (vld0 !== 1'b0) begin
      errors++;
      $display("FAIL t5_idle: got out_valid=%b want 0", vld0);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    q0 = 5; q1 = 6; q2 = 7; q3 = 8;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (vld0 !== 1'b1 || dat0 !== 16'sd6 || idx0 !== 2'd1) begin
      errors++;
      $display("FAIL t6_pre: got v=%b d=%0d i=%0d want 1 6 1", vld0, dat0, idx0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({vld0, dat0, idx0, last0, sat0} !== 21'd0) begin
      errors++;
      $display("FAIL t6_async: got v=%b d=%0d i=%0d l=%b s=%b want 0",
               vld0, dat0, idx0, last0, sat0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
      errors++;
      $display("FAIL t6_release: got rdy=%b v=%b want 1 0", rdy0, vld0);
    end
    @(negedge clk);
    q0 = 9; q1 = 10; q2 = 11; q3 = 12;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (vld0 !== 1'b1 || dat0 !== 16'sd9 || idx0 !== 2'd0) begin
      errors++;
      $display("FAIL t6_restart: got v=%b d=%0d i=%0d want 1 9 0", vld0, dat0, idx0);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frac0_basic();
    test_frac8_round();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
